// File: rtl/game_pkg.sv
// Shared types and constants for the win/lose reel game.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPIN1  = 3'd1,
        ST_SPIN2  = 3'd2,
        ST_SPIN3  = 3'd3,
        ST_EVAL   = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MATCH_NONE   = 2'd0,
        MATCH_PAIR   = 2'd1,
        MATCH_TRIPLE = 2'd2
    } match_t;

    localparam logic [3:0]  DIGIT_MAX         = 4'd9;
    localparam logic [7:0]  PAYOUT2_DEF       = 8'd2;
    localparam logic [7:0]  PAYOUT3_DEF       = 8'd10;
    localparam logic [31:0] MIN_SPIN_DEF      = 32'd1000;
    localparam logic [31:0] TIMEOUT_DEF       = 32'd5000000;
    localparam logic [31:0] RESULT_CYCLES_DEF = 32'd2000000;

    // The digit counters can briefly read 10 while wrapping; treat that as 0.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > DIGIT_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/reel_eval.sv
// Classifies three latched reels and returns the credit payout.
// Latency: combinational; backpressure: none.
module reel_eval
    import game_pkg::*;
#(
    parameter logic [7:0] PAYOUT2 = PAYOUT2_DEF,
    parameter logic [7:0] PAYOUT3 = PAYOUT3_DEF
) (
    input  logic [3:0] r1,
    input  logic [3:0] r2,
    input  logic [3:0] r3,
    output logic [7:0] payout,
    output logic [1:0] match
);

    always_comb begin
        payout = 8'd0;
        match  = MATCH_NONE;
        if (r1 == r2 && r2 == r3) begin
            payout = PAYOUT3;
            match  = MATCH_TRIPLE;
        end else if (r1 == r2 || r1 == r3 || r2 == r3) begin
            payout = PAYOUT2;
            match  = MATCH_PAIR;
        end
    end

endmodule

// File: rtl/reel_game_ctrl.sv
// Game sequencer: credits, three timed reel stops, evaluation and result display.
// Latency: stop -> disp frozen next cycle, final stop -> win/lose 2 cycles; backpressure: none, pulses outside their state are dropped.
module reel_game_ctrl
    import game_pkg::*;
#(
    parameter logic [31:0] MIN_SPIN      = MIN_SPIN_DEF,
    parameter logic [31:0] TIMEOUT       = TIMEOUT_DEF,
    parameter logic [31:0] RESULT_CYCLES = RESULT_CYCLES_DEF,
    parameter logic [7:0]  PAYOUT2       = PAYOUT2_DEF,
    parameter logic [7:0]  PAYOUT3       = PAYOUT3_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] count1,
    input  logic [3:0] count2,
    input  logic [3:0] count3,
    output logic [3:0] disp1,
    output logic [3:0] disp2,
    output logic [3:0] disp3,
    output logic [2:0] spinning,
    output logic [7:0] credits,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    state_t          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [7:0]      credits_q, credits_d;
    logic [2:0][3:0] reel_q, reel_d;
    logic [2:0]      spin_q, spin_d;
    logic            win_q, win_d, lose_q, lose_d;

    logic [7:0]      payout, add;
    logic [1:0]      match;
    logic [1:0]      idx;
    logic [3:0]      live;
    logic            stop_evt, start_ok;
    logic [9:0]      credit_sum;

    reel_eval #(
        .PAYOUT2 (PAYOUT2),
        .PAYOUT3 (PAYOUT3)
    ) u_eval (
        .r1     (reel_q[0]),
        .r2     (reel_q[1]),
        .r3     (reel_q[2]),
        .payout (payout),
        .match  (match)
    );

    always_comb begin
        idx  = 2'd0;
        live = count1;
        case (state_q)
            ST_SPIN2: begin idx = 2'd1; live = count2; end
            ST_SPIN3: begin idx = 2'd2; live = count3; end
            default:  ;
        endcase
    end

    assign stop_evt = (stop && (cnt_q >= MIN_SPIN - 32'd1)) || (cnt_q == TIMEOUT - 32'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reel_d   = reel_q;
        spin_d   = spin_q;
        win_d    = win_q;
        lose_d   = lose_q;
        start_ok = 1'b0;
        add      = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (start && credits_q != 8'd0) begin
                    start_ok = 1'b1;
                    state_d  = ST_SPIN1;
                    cnt_d    = 32'd0;
                    spin_d   = 3'b111;
                end
            end
            ST_SPIN1, ST_SPIN2, ST_SPIN3: begin
                if (stop_evt) begin
                    reel_d[idx] = clamp_digit(live);
                    spin_d[idx] = 1'b0;
                    cnt_d       = 32'd0;
                    case (state_q)
                        ST_SPIN1: state_d = ST_SPIN2;
                        ST_SPIN2: state_d = ST_SPIN3;
                        default:  state_d = ST_EVAL;
                    endcase
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_EVAL: begin
                add     = payout;
                state_d = ST_RESULT;
                cnt_d   = 32'd0;
                win_d   = (match != MATCH_NONE) && (payout != 8'd0);
                lose_d  = !((match != MATCH_NONE) && (payout != 8'd0));
            end
            ST_RESULT: begin
                if (cnt_q == RESULT_CYCLES - 32'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sum in 10 bits so coin, payout and the start debit net out before saturating.
    assign credit_sum = {2'b00, credits_q} + {9'd0, coin} + {2'b00, add} - {9'd0, start_ok};
    assign credits_d  = (credit_sum > 10'd255) ? 8'hFF : credit_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 32'd0;
            credits_q <= 8'd0;
            reel_q    <= '0;
            spin_q    <= 3'b000;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            credits_q <= credits_d;
            reel_q    <= reel_d;
            spin_q    <= spin_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    assign disp1    = spin_q[0] ? clamp_digit(count1) : reel_q[0];
    assign disp2    = spin_q[1] ? clamp_digit(count2) : reel_q[1];
    assign disp3    = spin_q[2] ? clamp_digit(count3) : reel_q[2];
    assign spinning = spin_q;
    assign credits  = credits_q;
    assign busy     = (state_q != ST_IDLE);
    assign win      = win_q;
    assign lose     = lose_q;

endmodule
